// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key pin and debounced key event bundle
//
// Ports (bundle members, NUM_KEYS bits each):
//   key_n       raw active-low button pins, asynchronous to clk
//   key_state   debounced level, 1 = pressed
//   key_press   one-cycle pulse on accepted press
//   key_release one-cycle pulse on accepted release
//   key_long    one-cycle pulse once per press after the long-hold time
// Modports: master = debouncer side, slave = consumer / pin driver side.
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        input  key_n,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );

    modport slave (
        output key_n,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-key synchroniser, debouncer and long-press detector
//
// Ports:
//   clk   system clock
//   nrst  asynchronous active-low reset
//   kif   key_debounce_if.master: key_n in; key_state, key_press,
//         key_release, key_long out (NUM_KEYS bits each)
// A shared 1 ms tick paces per-key debounce and hold counters. Each key runs
// IDLE -> PRESS_WAIT -> PRESSED <-> RELEASE_WAIT -> IDLE; all outputs are
// registered.
module key_debounce #(
    parameter int NUM_KEYS    = 4,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic           clk,
    input  logic           nrst,
    key_debounce_if.master kif
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int TW       = $clog2(TICK_DIV) + 1;
    localparam int DW       = $clog2(DEBOUNCE_MS) + 1;
    localparam int HW       = $clog2(LONG_MS) + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_MS);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Tick generator
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // Two-stage synchroniser; flops idle at 1 (button released)
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] pressed;

    assign pressed = ~sync2_q;

    // Per-key state
    logic [1:0]          state_q [NUM_KEYS];
    logic [1:0]          state_d [NUM_KEYS];
    logic [DW-1:0]       deb_q   [NUM_KEYS];
    logic [DW-1:0]       deb_d   [NUM_KEYS];
    logic [HW-1:0]       hold_q  [NUM_KEYS];
    logic [HW-1:0]       hold_d  [NUM_KEYS];
    logic [NUM_KEYS-1:0] kstate_q, kstate_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] long_q, long_d;

    function automatic logic [DW-1:0] deb_sat_inc(input logic [DW-1:0] v);
        return (v == DEB_MAX) ? v : v + DW'(1);
    endfunction

    function automatic logic [HW-1:0] hold_sat_inc(input logic [HW-1:0] v);
        return (v == HOLD_MAX) ? v : v + HW'(1);
    endfunction

    always_comb begin
        kstate_d  = kstate_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            deb_d[k]   = deb_q[k];
            hold_d[k]  = hold_q[k];
            case (state_q[k])
                ST_IDLE: begin
                    if (pressed[k]) begin
                        state_d[k] = ST_PRESS_WAIT;
                        deb_d[k]   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed[k]) begin
                        state_d[k] = ST_IDLE;
                    end else if (tick) begin
                        deb_d[k] = deb_sat_inc(deb_q[k]);
                        if (deb_sat_inc(deb_q[k]) == DEB_MAX) begin
                            state_d[k]  = ST_PRESSED;
                            kstate_d[k] = 1'b1;
                            press_d[k]  = 1'b1;
                            hold_d[k]   = '0;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (!pressed[k]) begin
                        state_d[k] = ST_RELEASE_WAIT;
                        deb_d[k]   = '0;
                    end else if (tick) begin
                        hold_d[k] = hold_sat_inc(hold_q[k]);
                        // Fires only on the step into saturation, so once per press
                        if (hold_q[k] != HOLD_MAX && hold_sat_inc(hold_q[k]) == HOLD_MAX) begin
                            long_d[k] = 1'b1;
                        end
                    end
                end
                default: begin // ST_RELEASE_WAIT
                    if (pressed[k]) begin
                        // Release bounce: return without clearing hold progress
                        state_d[k] = ST_PRESSED;
                    end else if (tick) begin
                        // Hold keeps counting so a long press can mature during release bounce
                        hold_d[k] = hold_sat_inc(hold_q[k]);
                        if (hold_q[k] != HOLD_MAX && hold_sat_inc(hold_q[k]) == HOLD_MAX) begin
                            long_d[k] = 1'b1;
                        end
                        deb_d[k] = deb_sat_inc(deb_q[k]);
                        if (deb_sat_inc(deb_q[k]) == DEB_MAX) begin
                            state_d[k]   = ST_IDLE;
                            kstate_d[k]  = 1'b0;
                            release_d[k] = 1'b1;
                            hold_d[k]    = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_cnt_q <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            kstate_q   <= '0;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= ST_IDLE;
                deb_q[k]   <= '0;
                hold_q[k]  <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= kif.key_n;
            sync2_q    <= sync1_q;
            kstate_q   <= kstate_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                deb_q[k]   <= deb_d[k];
                hold_q[k]  <= hold_d[k];
            end
        end
    end

    assign kif.key_state   = kstate_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
endmodule
